piso_4bit_tx: RTL and testbench

PISO_4BIT_TX -- requirements
Module: piso_4bit_tx

---
 rtl/piso_4bit_tx.sv | 117 +++++++++++
 tb/tb_piso_4bit_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_4bit_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// handshake and sends it MSB first, then pulses word_done for one cycle.
module piso_4bit_tx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             clr,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             sout_nxt;
    logic             sout_valid_nxt;
    logic             word_done_nxt;
    logic             busy_nxt;
    logic [IW-1:0]    idx;

    // Ready is a combinational view of the registered state, forced low in reset.
    assign din_ready = r_n && !clr && ((state == IDLE) || (state == DONE));

    // Bit presented on the next cycle: the counter still holds the current bit's index.
    assign idx = IW'(cnt - CW'(1));

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        cnt_nxt        = cnt;
        sout_nxt       = 1'b0;
        sout_valid_nxt = 1'b0;
        word_done_nxt  = 1'b0;
        busy_nxt       = 1'b0;

        if (clr) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (din_valid) begin
                        state_nxt      = SHIFT;
                        shreg_nxt      = din;
                        cnt_nxt        = CW'(WIDTH - 1);
                        sout_nxt       = din[WIDTH-1];
                        sout_valid_nxt = 1'b1;
                        busy_nxt       = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                SHIFT: begin
                    // Captured word is held static; the counter selects the bit.
                    if (cnt == '0) begin
                        state_nxt     = DONE;
                        word_done_nxt = 1'b1;
                    end else begin
                        cnt_nxt        = cnt - CW'(1);
                        sout_nxt       = shreg[idx];
                        sout_valid_nxt = 1'b1;
                        busy_nxt       = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            shreg      <= '0;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            word_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            shreg      <= shreg_nxt;
            cnt        <= cnt_nxt;
            sout       <= sout_nxt;
            sout_valid <= sout_valid_nxt;
            word_done  <= word_done_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_piso_4bit_tx.sv
// Bench for piso_4bit_tx: a per-cycle expected-output schedule model plus a
// downstream 4-bit SIPO, directed scenarios followed by random traffic.
module tb_piso_4bit_tx;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic         b;
        logic         v;
        logic         d;
        logic [W-1:0] w;
    } ent_t;

    logic         clk = 1'b0;
    logic         r_n = 1'b0;
    logic         clr = 1'b0;
    logic         din_valid = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_ready;
    logic         sout;
    logic         sout_valid;
    logic         word_done;
    logic         busy;

    logic [W-1:0] sipo_q;
    ent_t         mq[$];
    int           checks = 0;
    int           errors = 0;

    piso_4bit_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .r_n        (r_n),
        .clr        (clr),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .word_done  (word_done),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Downstream serial-in parallel-out register.
    always @(posedge clk or negedge r_n) begin
        if (!r_n) sipo_q <= '0;
        else if (sout_valid) sipo_q <= {sipo_q[W-2:0], sout};
    end

    // Model: each accepted word schedules W bit-cycles then one done-cycle.
    always @(negedge r_n) mq.delete();

    always @(posedge clk) begin
        if (r_n) begin
            bit can;
            logic [W-1:0] d;
            can = (mq.size() <= 1);
            d = din;
            if (clr) begin
                mq.delete();
            end else begin
                if (mq.size() > 0) void'(mq.pop_front());
                if (din_valid && can) begin
                    for (int i = W - 1; i >= 0; i--) mq.push_back('{b: d[i], v: 1'b1, d: 1'b0, w: d});
                    mq.push_back('{b: 1'b0, v: 1'b0, d: 1'b1, w: d});
                end
            end
        end
    end

    always @(negedge clk) begin
        ent_t e;
        logic exp_ready;
        e = (mq.size() > 0) ? mq[0] : '0;
        exp_ready = r_n && !clr && (mq.size() <= 1);
        check("sout", 32'(sout), 32'(e.b));
        check("sout_valid", 32'(sout_valid), 32'(e.v));
        check("word_done", 32'(word_done), 32'(e.d));
        check("busy", 32'(busy), 32'(e.v));
        check("din_ready", 32'(din_ready), 32'(exp_ready));
        if (e.d) check("sipo_word", 32'(sipo_q), 32'(e.w));
    end

    task automatic wait_done(input string nm, input int exp_lat, input logic [W-1:0] exp_word);
        int  n;
        int  nv;
        bit  seen;
        n = 0;
        nv = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (word_done) seen = 1;
            else if (sout_valid) nv++;
        end
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
        if (exp_lat > 0) begin
            check({nm, "_latency"}, 32'(n), 32'(exp_lat));
            check({nm, "_valid_cycles"}, 32'(nv), 32'(W));
        end
        check({nm, "_q"}, 32'(sipo_q), 32'(exp_word));
    endtask

    task automatic no_done_for(input string nm, input int cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (word_done) cnt++;
        end
        check({nm, "_no_done"}, 32'(cnt), 32'd0);
    endtask

    initial begin
        // Reset holds outputs low with no clock edge needed.
        #1;
        check("rst_sout", 32'(sout), 32'd0);
        check("rst_valid", 32'(sout_valid), 32'd0);
        check("rst_done", 32'(word_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(din_ready), 32'd0);
        repeat (3) @(posedge clk);

        // Single word 1011, handshake on the first edge after reset release.
        #2; r_n = 1'b1; din_valid = 1'b1; din = 4'b1011;
        @(posedge clk); #2; din_valid = 1'b0; din = '0;
        wait_done("single", 5, 4'b1011);

        // Back-to-back A then 5, second accepted in DONE.
        @(posedge clk); #2; din_valid = 1'b1; din = 4'hA;
        @(posedge clk); #2; din = 4'h5;
        wait_done("b2b_a", 5, 4'hA);
        @(posedge clk); #2; din_valid = 1'b0; din = '0;
        wait_done("b2b_5", 5, 4'h5);

        // Input changes during SHIFT are ignored.
        @(posedge clk); #2; din_valid = 1'b1; din = 4'h3;
        @(posedge clk); #2; din = 4'hF;
        @(negedge clk);
        check("ign_ready", 32'(din_ready), 32'd0);
        @(posedge clk); #2;
        @(posedge clk); #2; din_valid = 1'b0; din = '0;
        wait_done("ign", 0, 4'h3);

        // clr after two bits of C.
        @(posedge clk); #2;
        @(posedge clk); #2; din_valid = 1'b1; din = 4'hC;
        @(posedge clk); #2; din_valid = 1'b0; din = '0;
        @(posedge clk); #2; clr = 1'b1;
        @(negedge clk);
        check("clr_ready_low", 32'(din_ready), 32'd0);
        @(posedge clk); #2;
        check("clr_valid", 32'(sout_valid), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        check("clr_ready_after", 32'(din_ready), 32'd1);
        no_done_for("clr", 8);

        // clr together with din_valid in IDLE: no handshake.
        @(posedge clk); #2; clr = 1'b1; din_valid = 1'b1; din = 4'h7;
        @(posedge clk); #2; clr = 1'b0; din_valid = 1'b0; din = '0;
        @(negedge clk);
        check("clrv_busy", 32'(busy), 32'd0);
        check("clrv_valid", 32'(sout_valid), 32'd0);
        @(negedge clk);
        check("clrv_busy2", 32'(busy), 32'd0);

        // Async reset pulse mid-SHIFT.
        @(posedge clk); #2; din_valid = 1'b1; din = 4'h9;
        @(posedge clk); #2; din_valid = 1'b0; din = '0;
        @(posedge clk); #1; r_n = 1'b0;
        #1;
        check("arst_sout", 32'(sout), 32'd0);
        check("arst_valid", 32'(sout_valid), 32'd0);
        check("arst_done", 32'(word_done), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(din_ready), 32'd0);
        @(posedge clk); #2; r_n = 1'b1;
        no_done_for("arst", 8);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #2;
            din_valid = 1'($urandom_range(0, 1));
            din       = W'($urandom);
            clr       = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #2; din_valid = 1'b0; clr = 1'b0; din = '0;
        repeat (8) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
